uart_io_fifo: RTL
=================

UART_IO_FIFO -- requirements
Module: uart_io_fifo

Interface
- REQ-001 Parameter: FIFO_AW, default 4, log2 of FIFO depth; depth = 2^FIFO_AW entries of 8 bits.
- REQ-002 Port: clk  input  1  single clock; all state SHALL be clocked on its rising edge.
- REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
- REQ-004 Port: uart_io_char  input  8  character from io_uart_out.
- REQ-005 Port: uart_io_we  input  1  write strobe, one character per cycle.
- REQ-006 Port: uart_io_full  output  1  FIFO full; the writer SHALL NOT write while it is high.
- REQ-007 Port: tx_char  output  8  character presented to the UART transmitter.
- REQ-008 Port: tx_valid  output  1  tx_char is valid.
- REQ-009 Port: tx_ready  input  1  transmitter accepts tx_char this cycle.
- REQ-010 Port: fifo_count  output  FIFO_AW+1  number of stored characters.
- REQ-011 Port: overrun  output  1  sticky flag: a write was dropped.
- REQ-012 Port: ovr_clr  input  1  clears overrun.

Function
- REQ-013 Storage SHALL be a circular buffer: write pointer, read pointer (FIFO_AW bits, wrap modulo depth) and a registered count (0..depth).
- REQ-014 A write SHALL be accepted when uart_io_we=1 and uart_io_full=0; it stores uart_io_char at the write pointer and increments the write pointer.
- REQ-015 uart_io_full SHALL be high exactly when count == depth, decoded from the registered count.
- REQ-016 A write while uart_io_full=1 SHALL be dropped, SHALL leave the pointers and count unchanged, and SHALL set overrun on the next edge.
- REQ-017 ovr_clr=1 SHALL clear overrun on the next edge; a simultaneous dropped write SHALL win, leaving overrun=1.
- REQ-018 Output is show-ahead: tx_valid = (count != 0); tx_char = entry at the read pointer.
- REQ-019 A pop SHALL occur on tx_valid=1 and tx_ready=1; it increments the read pointer.
- REQ-020 tx_char and tx_valid SHALL be held stable while tx_valid=1 and tx_ready=0.
- REQ-021 Latency: a character written into an empty FIFO at edge N SHALL appear with tx_valid=1 in the cycle after edge N.
- REQ-022 Simultaneous accepted write and pop SHALL leave count unchanged.
- REQ-023 With count == depth, a write and a pop in the same cycle: the pop proceeds, the write is dropped (full was high), and overrun is set.
- REQ-024 With count == 0, a write and tx_ready=1 in the same cycle: no pop occurs and count becomes 1.
- REQ-025 tx_ready=1 while tx_valid=0 SHALL have no effect.
- REQ-026 fifo_count SHALL equal the registered count.

Reset
- REQ-027 On rst_n=0, immediately and independent of clk: pointers=0, count=0, overrun=0, CRLF state=HEAD.
- REQ-028 Resulting output values during reset: tx_valid=0, uart_io_full=0, fifo_count=0.
- REQ-029 Reset asserted mid-operation SHALL discard all stored characters; tx_char is don't-care while tx_valid=0.
- REQ-030 First write is accepted on the first rising edge after rst_n deasserts.

Configuration
- REQ-031 Macro UART_IO_CRLF_EN SHALL compile in line-feed expansion.
- REQ-032 When defined, a two-state machine {HEAD, LF} SHALL be added.
- REQ-033 In HEAD, when the head entry is 0x0A: tx_char=0x0D, tx_valid=1; a handshake SHALL move the state to LF without popping.
- REQ-034 In LF: tx_char=0x0A; a handshake SHALL pop and return the state to HEAD.
- REQ-035 In HEAD, a head entry other than 0x0A SHALL be handled as in REQ-018/019.
- REQ-036 The inserted 0x0D SHALL NOT occupy a FIFO entry or change fifo_count.
- REQ-037 When UART_IO_CRLF_EN is undefined, no expansion SHALL occur and no state register SHALL exist.

Verification (FIFO_AW=4, depth 16)
- REQ-038 Write 0x41,0x42,0x43 on consecutive cycles, tx_ready=1 -> tx_char 0x41,0x42,0x43 in order; tx_valid first high one cycle after the first write; fifo_count returns to 0.
- REQ-039 tx_ready=0, write 17 chars 0x00..0x10 -> uart_io_full=1 after the 16th, 0x10 dropped, overrun=1, fifo_count=16; drain -> 0x00..0x0F.
- REQ-040 FIFO full, write and tx_ready=1 in the same cycle -> pop occurs, fifo_count=15, overrun=1; ovr_clr pulse -> overrun=0.
- REQ-041 Write 20 chars, tx_ready toggled every cycle -> pointers wrap, all 20 chars output in order, no loss, overrun=0.
- REQ-042 Load 5 chars, assert rst_n=0 mid-stream -> tx_valid=0 and fifo_count=0 immediately; after release, a write of 0x55 is output next.
- REQ-043 UART_IO_CRLF_EN defined, write 0x48,0x0A,0x49 -> tx_char sequence 0x48,0x0D,0x0A,0x49; fifo_count peaks at 3; with tx_ready=0, 0x0D is held stable.

Source files
------------

// File: rtl/uart_io_fifo.sv
// Character FIFO between io_uart_out and the UART transmitter, show-ahead output, sticky overrun.
// Define UART_IO_CRLF_EN to expand each 0x0A into the sequence 0x0D,0x0A on the transmit side.
module uart_io_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         uart_io_char,
  input  logic               uart_io_we,
  output logic               uart_io_full,
  output logic [7:0]         tx_char,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overrun,
  input  logic               ovr_clr
);

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW+1)'(DEPTH);

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [7:0]         head;
  logic               wr_acc;
  logic               wr_drop;
  logic               handshake;
  logic               pop;

  assign head         = mem[rd_ptr];
  assign uart_io_full = (count == DEPTH_CNT);
  assign tx_valid     = (count != '0);
  assign fifo_count   = count;
  assign handshake    = tx_valid & tx_ready;
  assign wr_acc       = uart_io_we & ~uart_io_full;
  assign wr_drop      = uart_io_we &  uart_io_full;

`ifdef UART_IO_CRLF_EN
  typedef enum logic {HEAD, LF} crlf_state_e;

  crlf_state_e state;
  crlf_state_e state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HEAD;
    else        state <= state_next;
  end

  // A line feed at the head is sent twice: first as 0x0D (entry kept), then as itself (entry popped).
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_next = state;
    tx_char    = head;
    pop        = 1'b0;
    unique case (state)
      HEAD: begin
        if (tx_valid && head == 8'h0A) begin
          tx_char = 8'h0D;
          if (tx_ready) state_next = LF;
        end else begin
          pop = handshake;
        end
      end
      LF: begin
        tx_char = 8'h0A;
        if (handshake) begin
          pop        = 1'b1;
          state_next = HEAD;
        end
      end
      default: state_next = HEAD;
    endcase
  end
`else
  assign tx_char = head;
  assign pop     = handshake;
`endif

  // NOTE: the storage array has no reset; validity is carried entirely by count, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= uart_io_char;
  end

  // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)    rd_ptr <= rd_ptr + FIFO_AW'(1);
      unique case ({wr_acc, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A dropped write outranks a clear in the same cycle so no loss goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overrun <= 1'b0;
    else if (wr_drop) overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

endmodule
